// File: rtl/adder_ctrl_defs.sv
// Shared control definitions for the adder datapath: FSM state encodings
// (also decoded by the LED display logic) and the default settle interval.
package adder_ctrl_defs;

  localparam int SETTLE_CYCLES_DEF = 4;
  localparam int CNT_W             = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_LOAD_A  = 3'b001,
    S_WAIT_B  = 3'b010,
    S_LOAD_B  = 3'b011,
    S_SETTLE  = 3'b100,
    S_CAPTURE = 3'b101,
    S_SHOW    = 3'b110
  } ctrl_state_e;

endpackage

// File: rtl/step_edge_detect.sv
// Rising-edge detector for the debounced step button.
module step_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic step,
  output logic step_rise
);

  logic step_q;

  // Resetting to 1 means a button held through reset cannot produce an edge.
  always_ff @(posedge clk) begin
    if (reset) step_q <= 1'b1;
    else       step_q <= step;
  end

  assign step_rise = step & ~step_q;

endmodule

// File: rtl/adder_sequencer.sv
// Step-driven sequencer: loads operand A, then B, waits for the adder to
// settle, captures sum/carry and holds it for display.
module adder_sequencer
  import adder_ctrl_defs::*;
#(
  parameter int WIDTH         = 5,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic [WIDTH-1:0] sw,
  input  logic [WIDTH:0]   sum_in,
  output logic [WIDTH-1:0] reg_data,
  output logic             en_a,
  output logic             en_b,
  output logic [WIDTH:0]   result,
  output logic [2:0]       state,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             step_rise;

  step_edge_detect u_step_edge (
    .clk      (clk),
    .reset    (reset),
    .step     (step),
    .step_rise(step_rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Edges arriving outside IDLE/WAIT_B/SHOW are dropped, never queued.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    en_a     = 1'b0;
    en_b     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (step_rise) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        en_a    = 1'b1;
        state_d = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (step_rise) state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        en_b    = 1'b1;
        cnt_d   = CNT_LOAD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CAPTURE: begin
        result_d = sum_in;
        state_d  = S_SHOW;
      end
      S_SHOW: begin
        done = 1'b1;
        if (step_rise) state_d = S_LOAD_A;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign reg_data = sw;
  assign result   = result_q;
  assign state    = state_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Directed bench for adder_sequencer: default instance plus a SETTLE_CYCLES=1 instance.
module tb_adder_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, step;
  logic [4:0] sw, reg_data;
  logic [5:0] sum_in, result;
  logic [2:0] state;
  logic       en_a, en_b, busy, done;

  logic       rst1, step1;
  logic [4:0] sw1, reg_data1;
  logic [5:0] sum_in1, result1;
  logic [2:0] state1;
  logic       en_a1, en_b1, busy1, done1;

  adder_sequencer dut (
    .clk(clk), .reset(rst), .step(step), .sw(sw), .sum_in(sum_in),
    .reg_data(reg_data), .en_a(en_a), .en_b(en_b), .result(result),
    .state(state), .busy(busy), .done(done)
  );

  adder_sequencer #(.WIDTH(5), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(rst1), .step(step1), .sw(sw1), .sum_in(sum_in1),
    .reg_data(reg_data1), .en_a(en_a1), .en_b(en_b1), .result(result1),
    .state(state1), .busy(busy1), .done(done1)
  );

  // Operand registers and adder model
  logic [4:0] opa = '0, opb = '0, opa1 = '0, opb1 = '0;
  int ena_cnt = 0, enb_cnt = 0, ovl_cnt = 0, busy1_cnt = 0, ena1_cnt = 0, enb1_cnt = 0;
  assign sum_in  = {1'b0, opa}  + {1'b0, opb};
  assign sum_in1 = {1'b0, opa1} + {1'b0, opb1};

  always @(posedge clk) begin
    if (en_a)  opa  <= reg_data;
    if (en_b)  opb  <= reg_data;
    if (en_a1) opa1 <= reg_data1;
    if (en_b1) opb1 <= reg_data1;
    ena_cnt   <= ena_cnt + int'(en_a);
    enb_cnt   <= enb_cnt + int'(en_b);
    ena1_cnt  <= ena1_cnt + int'(en_a1);
    enb1_cnt  <= enb1_cnt + int'(en_b1);
    busy1_cnt <= busy1_cnt + int'(busy1);
    if ((en_a && en_b) || (en_a1 && en_b1)) ovl_cnt <= ovl_cnt + 1;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full operation on the default instance, starting in IDLE or SHOW with step low.
  task automatic do_op(input logic [4:0] a, input logic [4:0] b, input logic [5:0] exp, input string tag);
    int a0, b0;
    a0 = ena_cnt; b0 = enb_cnt;
    sw = a; step = 1'b1; tick;
    chk({tag, ".st_load_a"}, state, 1); chk({tag, ".en_a_hi"}, en_a, 1);
    step = 1'b0; tick;
    chk({tag, ".st_wait_b"}, state, 2); chk({tag, ".en_a_lo"}, en_a, 0);
    sw = b; step = 1'b1; tick;
    chk({tag, ".st_load_b"}, state, 3); chk({tag, ".en_b_hi"}, en_b, 1);
    step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk({tag, ".st_settle"}, state, 4); chk({tag, ".busy_hi"}, busy, 1);
    end
    tick;
    chk({tag, ".st_capture"}, state, 5); chk({tag, ".busy_lo"}, busy, 0);
    tick;
    chk({tag, ".st_show"}, state, 6); chk({tag, ".done"}, done, 1);
    chk({tag, ".result"}, result, exp);
    chk({tag, ".en_a_pulses"}, ena_cnt - a0, 1);
    chk({tag, ".en_b_pulses"}, enb_cnt - b0, 1);
  endtask

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int a0, b0;
    vecs[0] = '{a: 5'd7,  b: 5'd9,  exp: 6'd16};
    vecs[1] = '{a: 5'd31, b: 5'd31, exp: 6'b111110};
    vecs[2] = '{a: 5'd0,  b: 5'd0,  exp: 6'd0};
    vecs[3] = '{a: 5'd1,  b: 5'd31, exp: 6'd32};
    vecs[4] = '{a: 5'd21, b: 5'd10, exp: 6'd31};

    rst = 1'b1; step = 1'b0; sw = '0;
    rst1 = 1'b1; step1 = 1'b0; sw1 = '0;
    tick; tick;
    chk("rst.state", state, 0); chk("rst.result", result, 0);
    chk("rst.busy", busy, 0);   chk("rst.done", done, 0);
    chk("rst.en_a", en_a, 0);   chk("rst.en_b", en_b, 0);
    rst = 1'b0; rst1 = 1'b0;
    tick;
    chk("idle.stay", state, 0);

    // Held button from IDLE
    a0 = ena_cnt;
    sw = 5'd12; step = 1'b1;
    repeat (20) tick;
    chk("held.state", state, 2);
    chk("held.en_a_pulses", ena_cnt - a0, 1);

    // Step during SETTLE is ignored
    step = 1'b0; tick;
    a0 = ena_cnt; b0 = enb_cnt;
    sw = 5'd3; step = 1'b1; tick;
    chk("ign.st_load_b", state, 3);
    for (int i = 0; i < 4; i++) begin
      step = (i == 1);
      tick;
      chk("ign.st_settle", state, 4);
    end
    step = 1'b0;
    tick; chk("ign.st_capture", state, 5);
    tick; chk("ign.st_show", state, 6);
    chk("ign.result", result, 15);
    chk("ign.en_a_pulses", ena_cnt - a0, 0);
    chk("ign.en_b_pulses", enb_cnt - b0, 1);

    // Vector table; each operation after the first above starts from SHOW
    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // Reset in the second SETTLE cycle, with step held through reset
    sw = 5'd9; step = 1'b1; tick;
    step = 1'b0; tick;
    sw = 5'd2; step = 1'b1; tick;
    step = 1'b0; tick;
    tick;
    chk("mid.st_settle2", state, 4);
    rst = 1'b1; step = 1'b1; tick;
    chk("mid.state", state, 0); chk("mid.result", result, 0);
    chk("mid.busy", busy, 0);   chk("mid.done", done, 0);
    chk("mid.en_a", en_a, 0);   chk("mid.en_b", en_b, 0);
    rst = 1'b0;
    a0 = ena_cnt;
    repeat (5) tick;
    chk("mid.held_state", state, 0);
    chk("mid.held_no_load", ena_cnt - a0, 0);
    step = 1'b0; tick;
    step = 1'b1; tick;
    chk("mid.restart", state, 1);
    step = 1'b0; tick;
    chk("mid.restart_wait_b", state, 2);

    // SETTLE_CYCLES = 1 instance
    a0 = busy1_cnt;
    sw1 = 5'd3; step1 = 1'b1; tick;
    chk("s1.st_load_a", state1, 1);
    step1 = 1'b0; tick;
    sw1 = 5'd4; step1 = 1'b1; tick;
    chk("s1.st_load_b", state1, 3);
    step1 = 1'b0; tick;
    chk("s1.st_settle", state1, 4); chk("s1.busy_hi", busy1, 1);
    tick;
    chk("s1.st_capture", state1, 5); chk("s1.busy_lo", busy1, 0);
    tick;
    chk("s1.st_show", state1, 6); chk("s1.done", done1, 1);
    chk("s1.result", result1, 7);
    chk("s1.busy_cycles", busy1_cnt - a0, 1);

    // Step in SHOW goes straight to LOAD_A; result held until the next capture
    sw1 = 5'd5; step1 = 1'b1; tick;
    chk("s1r.st_load_a", state1, 1); chk("s1r.hold_la", result1, 7);
    step1 = 1'b0; tick;
    chk("s1r.hold_wb", result1, 7);
    sw1 = 5'd6; step1 = 1'b1; tick;
    chk("s1r.hold_lb", result1, 7);
    step1 = 1'b0; tick;
    chk("s1r.hold_settle", result1, 7);
    tick;
    chk("s1r.hold_capture", result1, 7);
    tick;
    chk("s1r.st_show", state1, 6);
    chk("s1r.result", result1, 11);
    chk("s1.en_a_total", ena1_cnt, 2);
    chk("s1.en_b_total", enb1_cnt, 2);

    chk("en_overlap", ovl_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/adder_sequencer.md
# adder_sequencer

Sequencer that drives the two 5-bit operand registers and the result capture for the RCA/CLA adder datapath on the Basys3 board. From one debounced step button and the 5 slide switches, it loads operand A, then operand B, then waits a fixed settle interval for the adder to propagate. It then captures the adder's sum and carry-out and holds them for display. It sits between the board I/O and the operand registers and adder, and owns all register enables.

## Interface

Parameters:
- WIDTH, 5, operand width in bits.
- SETTLE_CYCLES, 4, cycles waited after operand B loads before the sum is captured; legal range is 1 to 15.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  reset; synchronous, active-high.
- step  in  1  debounced, synchronized step button level.
- sw  in  WIDTH  operand value from the slide switches.
- sum_in  in  WIDTH+1  adder output; bit WIDTH is carry-out.
- reg_data  out  WIDTH  data bus to both operand registers; combinational copy of sw.
- en_a  out  1  load enable for operand register A.
- en_b  out  1  load enable for operand register B.
- result  out  WIDTH+1  captured sum; reset value 0.
- state  out  3  current FSM encoding, routed to LEDs; reset value 000.
- busy  out  1  high while in SETTLE.
- done  out  1  high while in SHOW, meaning result is valid.

## Operation

- step_q is a registered copy of step, with reset value 1. Because of that reset value, a button held through reset does not trigger.
- step_rise = step & ~step_q. Only rising edges advance the FSM; holding step does not retrigger.

FSM states, with Moore outputs:
- IDLE 000: wait for step_rise, then go to LOAD_A.
- LOAD_A 001: en_a=1 for exactly one cycle, then go to WAIT_B unconditionally.
- WAIT_B 010: wait for step_rise, then go to LOAD_B.
- LOAD_B 011: en_b=1 for exactly one cycle.
  - Load the counter with SETTLE_CYCLES-1.
  - Go to SETTLE.
- SETTLE 100: busy=1; the counter decrements each cycle. When the counter is 0, go to CAPTURE.
- CAPTURE 101: result <= sum_in at the end of the cycle, then go to SHOW.
- SHOW 110: done=1; result holds its value. On step_rise, go to LOAD_A to start a new operation without passing through IDLE.

State 111 is unreachable. If it is ever entered, the next state is IDLE.

Other rules:
- step_rise in LOAD_A, LOAD_B, SETTLE or CAPTURE is ignored and not queued.
- en_a and en_b are never high at the same time. Outside their own states, both are 0.
- result changes only in CAPTURE and on reset.
- reset in any state, including mid-SETTLE, forces on the next edge:
  - state IDLE, counter 0, step_q 1, result 0.
  - all enables 0, busy 0, done 0.
  - The operand registers themselves are not reset by this block.

## Timing

- step_rise true before edge k means LOAD_A occupies cycle k to k+1. Register A captures sw at edge k+1.
- Entering LOAD_B at edge m:
  - Register B loads at m+1.
  - SETTLE occupies m+1 to m+1+SETTLE_CYCLES.
  - CAPTURE occupies the following cycle.
  - result and done update at m+2+SETTLE_CYCLES, which is m+6 at the default.
- sum_in must be stable from edge m+1 until the capture edge. The SETTLE interval guarantees this.
- The minimum cycle count from a step that enters LOAD_B to done is SETTLE_CYCLES+2.

## Structure

- Shared definitions file adder_ctrl_defs: the 3-bit state encodings (S_IDLE through S_SHOW) and the SETTLE_CYCLES default. Display logic decodes state from this same file.
- One sub-module, step_edge_detect: the step_q register with reset value 1, producing the step_rise output.
- The counter width is 4 bits, sized for SETTLE_CYCLES up to 15.

## Test plan

- Basic add: sw=7 then step; sw=9 then step; sum_in is modelled as A+B. Require en_a and en_b to be one-cycle pulses, busy for 4 cycles, then result=6'd16 and done=1 with state=110.
- Overflow: A=31, B=31. Require result=6'b111110, with carry bit 5 = 1.
- Held button: step held high for 20 cycles from IDLE. Require exactly one en_a pulse and state=010 afterwards.
- Ignored step: pulse step during SETTLE. Require no extra pulse on en_a or en_b, and the capture cycle unchanged.
- Reset mid-operation: assert reset in the second SETTLE cycle. Require state=000, result=0, busy=0 and done=0 on the next edge. Also require that step held through reset produces no LOAD_A after release.
- SETTLE_CYCLES=1: busy is high for exactly one cycle, and result is valid at LOAD_B entry + 3. Also step in SHOW goes directly to LOAD_A with result held until the next CAPTURE.
